// File: rtl/instr_realign.sv
`default_nettype none
// ============================================================================
// Module   : instr_realign
// Purpose  : Fetch-to-decode halfword realignment buffer. Accepts 64-bit fetch
//            packets that may start at any halfword and stores them as 16-bit
//            halfwords in a circular array. Presents one whole instruction per
//            cycle (16-bit RVC or 32-bit) with its pc and an is_rvc flag.
//            32-bit instructions that straddle packet boundaries are held back
//            until both halves are present.
// Ports    : CLK, RSTn (async active-low)
//            flush                         - drop buffered stream
//            if_valid/if_ready/if_data/if_pc - fetch packet handshake
//            instr_valid/instr_ready       - decode handshake
//            instr, pc, is_rvc             - head instruction
// Revision : 1.0 - initial release
// ============================================================================
module instr_realign #(
  parameter int HW_DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        flush,
  input  logic        if_valid,
  output logic        if_ready,
  input  logic [63:0] if_data,
  input  logic [63:0] if_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [63:0] pc,
  output logic        is_rvc
);

  localparam int PTR_W = $clog2(HW_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [15:0]      r_mem [HW_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [63:0]      r_head_pc;
  logic             r_pc_valid;

  logic [1:0]       w_off;
  logic [CNT_W-1:0] w_n_push;
  logic [CNT_W-1:0] w_n_pop;
  logic             w_push;
  logic             w_pop;
  logic [15:0]      w_hw0;
  logic [15:0]      w_hw1;
  logic             w_unused;

  // Byte bit 0 of the fetch pc is always zero for halfword-aligned code.
  assign w_unused = if_pc[0];

  // First valid halfword inside the packet; only halfwords off..3 are stored.
  assign w_off    = if_pc[2:1];
  assign w_n_push = CNT_W'(3'd4 - {1'b0, w_off});

  // Ready depends only on the registered count, so there is no path from
  // instr_ready back to the fetch side.
  assign if_ready = (r_count <= CNT_W'(HW_DEPTH - 4));
  assign w_push   = if_valid & if_ready & ~flush;

  assign w_hw0  = r_mem[r_rd_ptr];
  assign w_hw1  = r_mem[r_rd_ptr + PTR_W'(1)];
  assign is_rvc = (w_hw0[1:0] != 2'b11);

  // A 32-bit instruction needs both halves already stored; a same-cycle push
  // cannot complete it early because the array is read from registered state.
  assign instr_valid = r_pc_valid & ~flush &
                       (((r_count >= CNT_W'(1)) & is_rvc) | (r_count >= CNT_W'(2)));
  assign instr   = is_rvc ? {16'h0000, w_hw0} : {w_hw1, w_hw0};
  assign pc      = r_head_pc;
  assign w_n_pop = is_rvc ? CNT_W'(1) : CNT_W'(2);
  assign w_pop   = instr_valid & instr_ready;

  // Halfword storage: not reset, contents are only meaningful below count.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      for (int k = 0; k < 4; k++) begin
        if (k >= int'(w_off)) begin
          r_mem[r_wr_ptr + PTR_W'(k) - PTR_W'(w_off)] <= if_data[16*k +: 16];
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_head_pc  <= '0;
      r_pc_valid <= 1'b0;
    end else if (flush) begin
      // head_pc is left alone: it is reloaded by the first push of the next stream.
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_count    <= '0;
      r_pc_valid <= 1'b0;
    end else begin
      r_count <= r_count + (w_push ? w_n_push : '0) - (w_pop ? w_n_pop : '0);
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_push);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(w_n_pop);
      end
      // The first packet of a stream sets the pc; later packets are
      // sequential and only contribute their halfword offset. A pop cannot
      // coincide with the first push because instr_valid needs pc_valid.
      if (w_push && !r_pc_valid) begin
        r_head_pc  <= {if_pc[63:1], 1'b0};
        r_pc_valid <= 1'b1;
      end else if (w_pop) begin
        r_head_pc <= r_head_pc + {{(64-CNT_W-1){1'b0}}, w_n_pop, 1'b0};
      end
    end
  end

endmodule
`default_nettype wire
